// File: rtl/fetch_unit_if.sv
// Fetch front-end bus bundle: instruction-memory request channel plus decode-side instruction channel.
// Latency: none (wires only).
// Backpressure: mem_ack ends a memory request; inst_ready accepts the head instruction when inst_valid=1.
interface fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  // fetch unit side
  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc,
    input  mem_ack, mem_rdata, inst_ready
  );

  // memory + decode side
  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc,
    output mem_ack, mem_rdata, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, one-outstanding memory request, prefetch FIFO, redirect/halt.
// Latency: mem_ack in cycle N presents the instruction at the FIFO head in cycle N+1.
// Backpressure: a fetch is only issued when the FIFO has room for it, so a stalled decode stops fetching.
module fetch_unit #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hlt,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  fetch_unit_if.master             bus,
  output logic [ADDR_W-1:0]        pc,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              drop_q;
  logic [ADDR_W-1:0] pc_q;
  logic              halted_q;
  logic [CW-1:0]     count_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [DATA_W-1:0] fifo_inst [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];

  logic              ack;
  logic              push;
  logic              pop;
  logic              issue;
  logic              req_nxt;
  logic              drop_nxt;
  logic [CW-1:0]     count_nxt;
  logic [ADDR_W-1:0] pc_nxt;

  // Next-state decisions: ack/push/pop, issue, next pc and drop flag.
  always_comb begin
    ack       = mem_req_q && bus.mem_ack;
    // Redirect kills both the acked data and any pop in the same cycle.
    push      = ack && !drop_q && !redirect;
    pop       = (count_q != '0) && bus.inst_ready && !redirect;
    count_nxt = count_q + CW'(push) - CW'(pop);

    pc_nxt = pc_q;
    if (redirect) begin
      pc_nxt = redirect_pc;
    end else if (push) begin
      pc_nxt = mem_addr_q + ADDR_W'(PC_STEP);
    end

    // The request slot is free if idle or finishing with useful data this cycle.
    // A discarded ack or a redirect holds off the next fetch for one cycle.
    // count_nxt already holds this cycle's push, so the new request's slot is
    // accounted for by requiring count_nxt < DEPTH.
    issue = !hlt && !redirect
          && (!mem_req_q || (ack && !drop_q))
          && (count_nxt < CW'(DEPTH));

    req_nxt = mem_req_q;
    if (issue) begin
      req_nxt = 1'b1;
    end else if (ack) begin
      req_nxt = 1'b0;
    end

    drop_nxt = drop_q;
    if (redirect && mem_req_q && !bus.mem_ack) begin
      drop_nxt = 1'b1;
    end else if (ack) begin
      drop_nxt = 1'b0;
    end
  end

  // Control state: request, pc, drop flag, FIFO pointers/count and halted status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= ADDR_W'(RESET_PC);
      drop_q     <= 1'b0;
      pc_q       <= ADDR_W'(RESET_PC);
      halted_q   <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      mem_req_q <= req_nxt;
      if (issue) begin
        mem_addr_q <= pc_nxt;
      end
      drop_q   <= drop_nxt;
      pc_q     <= pc_nxt;
      halted_q <= hlt && !req_nxt;
      if (redirect) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        count_q <= count_nxt;
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
      end
    end
  end

  // FIFO storage: write the acked word with its fetch address.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr_q] <= bus.mem_rdata;
      fifo_pc[wr_ptr_q]   <= mem_addr_q;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst       = fifo_inst[rd_ptr_q];
  assign bus.inst_pc    = fifo_pc[rd_ptr_q];
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign occupancy      = count_q;
endmodule
